// File: rtl/clock_pkg.sv
// Shared types and BCD helpers for the time-of-day core.
// Two-digit BCD values are handled digit-wise throughout; nothing goes through binary.
package clock_pkg;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] units;
   } bcd2_t;

   typedef struct packed {
      logic  wrapped;
      bcd2_t next;
   } bcd2_inc_t;

   typedef enum logic {
      IDLE = 1'b0,
      RING = 1'b1
   } alarm_state_t;

   localparam logic [7:0] MAX_SEC  = 8'h59;
   localparam logic [7:0] MAX_MIN  = 8'h59;
   localparam logic [7:0] MAX_HOUR = 8'h23;

   // With both digits legal, BCD ordering matches numeric ordering.
   function automatic logic bcd2_valid(input logic [7:0] value, input logic [7:0] max);
      return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
   endfunction

   function automatic bcd2_inc_t bcd2_inc(input logic [7:0] value, input logic [7:0] max);
      bcd2_inc_t r;
      r.wrapped = 1'b0;
      r.next    = value;
      if (value == max) begin
         r.wrapped = 1'b1;
         r.next    = 8'h00;
      end else if (value[3:0] == 4'd9) begin
         r.next.tens  = value[7:4] + 4'd1;
         r.next.units = 4'd0;
      end else begin
         r.next.units = value[3:0] + 4'd1;
      end
      return r;
   endfunction

   // 24 h BCD hour to 12 h display form: 00->12, 13..23->01..11.
   function automatic logic [7:0] to_12h(input logic [7:0] h24);
      logic [7:0] r;
      r = h24;
      if (h24 == 8'h00) begin
         r = 8'h12;
      end else if (h24 > 8'h12) begin
         if (h24[7:4] == 4'd1) begin
            r = {4'd0, h24[3:0] - 4'd2};
         end else if (h24[3:0] < 4'd2) begin
            r = {4'd0, h24[3:0] + 4'd8};
         end else begin
            r = {4'd1, h24[3:0] - 4'd2};
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/digital_clock_core_bcd2_counter.sv
// Two-digit BCD counter wrapping MAX->00; load has priority over inc.
// wrap is combinational and flags the increment that rolls over.
module bcd2_counter
   import clock_pkg::*;
#(
   parameter logic [7:0] MAX = 8'h59
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] val,
   output logic       wrap
);

   logic [7:0] val_reg;
   bcd2_inc_t  step;

   assign step = bcd2_inc(val_reg, MAX);

   always_ff @(posedge clock) begin
      if (reset) begin
         val_reg <= 8'h00;
      end else if (load) begin
         val_reg <= load_val;
      end else if (inc) begin
         val_reg <= step.next;
      end
   end

   assign val  = val_reg;
   assign wrap = inc && !load && step.wrapped;

endmodule

// File: rtl/digital_clock_core.sv
// Time-of-day core: 1 Hz prescaler, cascaded BCD h:m:s counters, load/adjust,
// 12/24 h display and one daily alarm with a self-clearing ring.
module digital_clock_core
   import clock_pkg::*;
#(
   parameter int TICK_DIV  = 50000000,
   parameter int HOUR_12   = 0,
   parameter int RING_SECS = 60
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       run,
   input  logic       load,
   input  logic [7:0] load_h,
   input  logic [7:0] load_m,
   input  logic [7:0] load_s,
   input  logic       inc_min,
   input  logic       inc_hour,
   input  logic       alarm_wr,
   input  logic       alarm_en,
   input  logic       alarm_clr,
   output logic [7:0] h_bcd,
   output logic [7:0] m_bcd,
   output logic [7:0] s_bcd,
   output logic       pm,
   output logic       tick_1hz,
   output logic       carry_min,
   output logic       carry_hour,
   output logic       load_err,
   output logic       alarm_ring
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int RW = $clog2(RING_SECS + 1);
   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);

   logic [PW-1:0] presc_reg;
   logic          tick;
   logic          time_ok, alarm_ok, do_load;
   logic          man_min, man_hour;
   logic          sec_inc, sec_load, sec_wrap, min_inc, min_wrap, hour_inc;
   logic          hour_wrap_unused;
   logic [7:0]    sec_load_val;
   logic [7:0]    sec_val, min_val, hour_val;
   logic          load_err_reg;
   logic [7:0]    alarm_h_reg, alarm_m_reg;
   bcd2_inc_t     min_step, hour_step;
   logic [7:0]    next_hour;
   logic          trigger;
   alarm_state_t  state_reg, state_next;
   logic [RW-1:0] ring_cnt_reg, ring_cnt_next;

   assign time_ok  = bcd2_valid(load_h, MAX_HOUR) && bcd2_valid(load_m, MAX_MIN)
                     && bcd2_valid(load_s, MAX_SEC);
   assign alarm_ok = bcd2_valid(load_h, MAX_HOUR) && bcd2_valid(load_m, MAX_MIN);
   assign do_load  = load && time_ok;

   // Prescaler freezes (without clearing) while stopped; a good load restarts the second.
   always_ff @(posedge clock) begin
      if (reset) begin
         presc_reg <= '0;
      end else if (do_load) begin
         presc_reg <= '0;
      end else if (run) begin
         presc_reg <= (presc_reg == PRE_LAST) ? '0 : presc_reg + PW'(1);
      end
   end

   assign tick     = run && (presc_reg == PRE_LAST);
   assign tick_1hz = tick;

   // Any load pulse, even a rejected one, blocks tick and adjust for that cycle.
   assign sec_inc      = tick && !load;
   assign man_min      = !run && !load && inc_min;
   assign man_hour     = !run && !load && inc_hour;
   assign sec_load     = do_load || man_min;
   assign sec_load_val = do_load ? load_s : 8'h00;
   assign min_inc      = sec_wrap || man_min;
   assign carry_min    = sec_wrap;
   assign carry_hour   = sec_wrap && min_wrap;
   assign hour_inc     = carry_hour || man_hour;

   bcd2_counter #(.MAX(MAX_SEC)) u_sec (
      .clock    (clock),
      .reset    (reset),
      .inc      (sec_inc),
      .load     (sec_load),
      .load_val (sec_load_val),
      .val      (sec_val),
      .wrap     (sec_wrap)
   );

   bcd2_counter #(.MAX(MAX_MIN)) u_min (
      .clock    (clock),
      .reset    (reset),
      .inc      (min_inc),
      .load     (do_load),
      .load_val (load_m),
      .val      (min_val),
      .wrap     (min_wrap)
   );

   bcd2_counter #(.MAX(MAX_HOUR)) u_hour (
      .clock    (clock),
      .reset    (reset),
      .inc      (hour_inc),
      .load     (do_load),
      .load_val (load_h),
      .val      (hour_val),
      .wrap     (hour_wrap_unused)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         load_err_reg <= 1'b0;
         alarm_h_reg  <= 8'h00;
         alarm_m_reg  <= 8'h00;
      end else begin
         load_err_reg <= (load && !time_ok) || (alarm_wr && !alarm_ok);
         if (alarm_wr && alarm_ok) begin
            alarm_h_reg <= load_h;
            alarm_m_reg <= load_m;
         end
      end
   end

   // Match against the h:m the counters will hold after this minute rollover.
   assign min_step  = bcd2_inc(min_val, MAX_MIN);
   assign hour_step = bcd2_inc(hour_val, MAX_HOUR);
   assign next_hour = min_step.wrapped ? hour_step.next : hour_val;
   assign trigger   = alarm_en && sec_wrap && (min_step.next == alarm_m_reg)
                      && (next_hour == alarm_h_reg);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= IDLE;
         ring_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         ring_cnt_reg <= ring_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      ring_cnt_next = ring_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (trigger && !alarm_clr) begin
               state_next    = RING;
               ring_cnt_next = '0;
            end
         end
         RING: begin
            if (alarm_clr || !alarm_en || (tick && ring_cnt_reg == RING_LAST)) begin
               state_next = IDLE;
            end else if (tick) begin
               ring_cnt_next = ring_cnt_reg + RW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign alarm_ring = (state_reg == RING);
   assign load_err   = load_err_reg;
   assign h_bcd      = (HOUR_12 != 0) ? to_12h(hour_val) : hour_val;
   assign m_bcd      = min_val;
   assign s_bcd      = sec_val;
   assign pm         = (hour_val >= 8'h12);

endmodule
